led_sequencer: RTL
==================

# led_sequencer

Parametrised LED pattern sequencer: a register-file pattern table of DEPTH entries, LED_COUNT bits wide, stepped forward or backward by single-cycle rising-edge pulses or by an internal auto-advance tick. It replaces the fixed ten-step, five-LED driver in board-level LED paths. It sits behind the edge detectors/debouncers and drives the LED pins directly. The pattern table is host-writable and has a programmable active length.

## Interface
Parameters:
- LED_COUNT, 5, LED output width (≥1)
- DEPTH, 10, pattern table entries (≥2); IDX_W = $clog2(DEPTH), LEN_W = $clog2(DEPTH+1)
- TICK_DIV, 50_000_000, clk cycles per auto-advance step (≥2); CNT_W = $clog2(TICK_DIV)

Ports:
- Clock and reset: one clock, `clk`; reset is asynchronous and active-low, `async_nreset`.
- clk  in  1  system clock
- async_nreset  in  1  asynchronous active-low reset
- next_led_re  in  1  one-cycle step-forward pulse
- prev_led_re  in  1  one-cycle step-backward pulse
- auto_en  in  1  1 = auto-advance on internal tick
- auto_dir  in  1  auto direction: 0 forward, 1 backward
- seq_len  in  LEN_W  active sequence length; 0 or >DEPTH means DEPTH
- wr_en  in  1  table write strobe
- wr_addr  in  IDX_W  table write address; ≥DEPTH ignored
- wr_data  in  LED_COUNT  table write data
- led  out  LED_COUNT  registered LED drive
- idx  out  IDX_W  current table index
- wrap  out  1  one-cycle pulse when idx wraps in either direction

## Operation
- Effective length L = (seq_len==0 || seq_len>DEPTH) ? DEPTH : seq_len. If L==1, idx stays 0 and wrap never asserts.
- Step request, in priority order:
  - next_led_re && prev_led_re: no step.
  - next_led_re: forward step.
  - prev_led_re: backward step.
  - else, auto_en && tick: step in auto_dir.
- Forward step: idx==L-1 → 0 with wrap=1; idx≥L (after L shrinks) → 0 with wrap=1; otherwise idx+1.
- Backward step: idx==0 or idx≥L → L-1 with wrap=1; otherwise idx-1.
- Prescaler:
  - Counts 0..TICK_DIV-1 while auto_en=1; tick=1 when count==TICK_DIV-1, then count returns to 0.
  - Held at 0 while auto_en=0.
  - Cleared on any manual pulse (next or prev), including a cancelled simultaneous pair. Auto spacing therefore restarts from the last manual action.
  - A manual pulse coinciding with tick consumes the tick: one step, in the manual direction.
- Table writes take effect at the clock edge. wr_addr ≥ DEPTH is a no-op.
- Reset table contents: entry 0 = all zeros; entry i (i≥1) = one-hot bit ((i-1) mod LED_COUNT).
- led is loaded every cycle with the table entry at idx_next. If wr_en targets idx_next in the same cycle, led takes wr_data (write-through).

## Timing
- Reset values: idx=0, led=0, wrap=0, prescaler=0, table = the reset contents above.
- Step latency: a pulse in cycle N gives new idx and led values after edge N, visible in cycle N+1. wrap is registered, with the same timing, and lasts one cycle.
- Auto mode: with auto_en held high from cycle 0, the first step is visible after TICK_DIV edges, then every TICK_DIV cycles.
- Write latency: an entry written in cycle N appears on led in cycle N+1 if that entry is displayed.
- seq_len changes take effect immediately for the next step; idx is not moved until a step occurs.
- Reset asserted mid-sequence: all state returns to reset values asynchronously. Table writes in progress are lost.
- Inputs are synchronous to clk; pulse inputs are assumed already edge-detected (one cycle wide).

## Structure
- Shared package `led_pkg`: default LED_COUNT/DEPTH/TICK_DIV constants, DIR_FWD/DIR_REV constants, and the reset-pattern function (index → one-hot pattern).
- Sub-module `led_tick_gen`: prescaler with inputs en and clr, output tick, parameter TICK_DIV.
- Top-level `led_sequencer`: step arbitration, index register, table register file, output register.

## Test plan
- Reset, then 10 next_led_re pulses with LED_COUNT=5, DEPTH=10, seq_len=0:
  - led sequence 00001, 00010, 00100, 01000, 10000, 00001, 00010, 00100, 01000, then 00000.
  - wrap pulses exactly once, on the 10th pulse.
- From idx=0, one prev_led_re → idx=9, led=01000, wrap=1. Simultaneous next+prev → idx unchanged, wrap=0.
- seq_len=4, idx=7, one next_led_re → idx=0, wrap=1. Then 4 prev pulses → idx 3, 2, 1, 0.
- TICK_DIV=4, auto_en=1, auto_dir=1 from idx=2 → idx=1 after 4 cycles, 0 after 8, 9 after 12.
  - A next pulse at cycle 6 → idx advances, and the next auto step lands at cycle 10.
- Write wr_addr=3, wr_data=11111 while idx=3 → led=11111 the next cycle. wr_addr=12 → table unchanged.
- Assert async_nreset low mid-auto-run between clock edges → led=0, idx=0 immediately. The table returns to reset contents.

Source files
------------

// File: rtl/led_pkg.sv
// Shared constants, step encoding and power-on pattern helper for the LED sequencer.
package led_pkg;

    localparam int DEF_LED_COUNT = 5;
    localparam int DEF_DEPTH     = 10;
    localparam int DEF_TICK_DIV  = 50_000_000;
    localparam int MAX_LEDS      = 64;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_FWD,
        STEP_REV
    } step_e;

    // Entry 0 is dark; entry i walks a single lit LED, wrapping over the LED count.
    function automatic logic [MAX_LEDS-1:0] reset_pattern(input int unsigned entry,
                                                          input int unsigned led_count);
        if (entry == 0) begin
            return '0;
        end
        return MAX_LEDS'(1) << ((entry - 1) % led_count);
    endfunction

endpackage

// File: rtl/led_sequencer_if.sv
// Control, table-write and LED-drive signals shared between the sequencer and its host.
interface led_sequencer_if
    import led_pkg::*;
#(
    parameter int LED_COUNT = DEF_LED_COUNT,
    parameter int DEPTH     = DEF_DEPTH
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int LEN_W = $clog2(DEPTH + 1);

    logic                 next_led_re;
    logic                 prev_led_re;
    logic                 auto_en;
    logic                 auto_dir;
    logic [LEN_W-1:0]     seq_len;
    logic                 wr_en;
    logic [IDX_W-1:0]     wr_addr;
    logic [LED_COUNT-1:0] wr_data;
    logic [LED_COUNT-1:0] led;
    logic [IDX_W-1:0]     idx;
    logic                 wrap;

    modport master (
        output next_led_re, prev_led_re, auto_en, auto_dir, seq_len,
        output wr_en, wr_addr, wr_data,
        input  led, idx, wrap
    );

    modport slave (
        input  next_led_re, prev_led_re, auto_en, auto_dir, seq_len,
        input  wr_en, wr_addr, wr_data,
        output led, idx, wrap
    );

endinterface

// File: rtl/led_tick_gen.sv
// Auto-advance prescaler: one-cycle tick every TICK_DIV enabled cycles, restartable by clr.
module led_tick_gen
    import led_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic async_nreset,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int              CNT_W   = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        tick  = en && (cnt_q == CNT_MAX);
        cnt_d = cnt_q + CNT_W'(1);
        if (!en || clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge async_nreset) begin
        // NOTE: state uses non-blocking assignment so every flop samples pre-edge values.
        if (!async_nreset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: host-writable pattern table stepped by manual pulses or auto ticks.
module led_sequencer
    import led_pkg::*;
#(
    parameter int LED_COUNT = DEF_LED_COUNT,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int TICK_DIV  = DEF_TICK_DIV
) (
    input  logic           clk,
    input  logic           async_nreset,
    led_sequencer_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int LEN_W = $clog2(DEPTH + 1);

    logic                 tick;
    logic                 manual;
    step_e                step;
    logic [LEN_W-1:0]     eff_len;
    logic [LEN_W-1:0]     last_idx;
    logic [LEN_W-1:0]     idx_ext;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 wrap_q, wrap_d;
    logic [LED_COUNT-1:0] led_q, led_d;
    logic [LED_COUNT-1:0] pat_q [DEPTH];
    logic                 wr_hit;

    // A cancelled next+prev pair still counts as manual activity for the prescaler.
    assign manual = bus.next_led_re | bus.prev_led_re;

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk          (clk),
        .async_nreset (async_nreset),
        .en           (bus.auto_en),
        .clr          (manual),
        .tick         (tick)
    );

    always_comb begin
        step = STEP_NONE;
        if (bus.next_led_re && bus.prev_led_re) begin
            step = STEP_NONE;
        end else if (bus.next_led_re) begin
            step = STEP_FWD;
        end else if (bus.prev_led_re) begin
            step = STEP_REV;
        end else if (bus.auto_en && tick) begin
            step = (bus.auto_dir == DIR_FWD) ? STEP_FWD : STEP_REV;
        end
    end

    always_comb begin
        eff_len = bus.seq_len;
        if (bus.seq_len == '0 || bus.seq_len > LEN_W'(DEPTH)) begin
            eff_len = LEN_W'(DEPTH);
        end
        last_idx = eff_len - LEN_W'(1);
        idx_ext  = LEN_W'(idx_q);
    end

    // idx may sit beyond a freshly shortened length; either direction then wraps.
    always_comb begin
        idx_d  = idx_q;
        wrap_d = 1'b0;
        if (eff_len == LEN_W'(1)) begin
            if (step != STEP_NONE) begin
                idx_d = '0;
            end
        end else begin
            unique case (step)
                STEP_FWD: begin
                    if (idx_ext >= last_idx) begin
                        idx_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                STEP_REV: begin
                    if (idx_q == '0 || idx_ext >= eff_len) begin
                        idx_d  = IDX_W'(last_idx);
                        wrap_d = 1'b1;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign wr_hit = bus.wr_en && (32'(bus.wr_addr) < DEPTH);

    always_comb begin
        led_d = pat_q[idx_d];
        if (wr_hit && bus.wr_addr == idx_d) begin
            led_d = bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge async_nreset) begin
        // NOTE: the table is a flop array rather than RAM because reset must restore its patterns.
        if (!async_nreset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pat_q[i] <= LED_COUNT'(reset_pattern(i, LED_COUNT));
            end
        end else if (wr_hit) begin
            pat_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            idx_q  <= '0;
            wrap_q <= 1'b0;
            led_q  <= '0;
        end else begin
            idx_q  <= idx_d;
            wrap_q <= wrap_d;
            led_q  <= led_d;
        end
    end

    assign bus.idx  = idx_q;
    assign bus.wrap = wrap_q;
    assign bus.led  = led_q;

endmodule
